// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the MIPS fetch stage: reset/bubble constants, jump
// select encoding, fetch FSM states and the pseudo-direct jump target helper.
package fetch_stage_pkg;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

  typedef enum logic [1:0] {
    JUMP_NONE = 2'b00,
    JUMP_J    = 2'b01,
    JUMP_JR   = 2'b10,
    JUMP_RSVD = 2'b11   // treated as no jump
  } jump_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_DISCARD = 2'b01,  // waiting out a fetch whose word is no longer wanted
    ST_HALT    = 2'b10
  } fetch_state_e;

  // J/JAL target: upper nibble of the delay-free PC+4, 26-bit index, word aligned.
  function automatic logic [31:0] j_target(input logic [31:0] pc4,
                                           input logic [31:0] instr);
    return {pc4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
//  clk, reset      : clock, async active-high reset (loads a bubble)
//  en              : update enable (low = hold every field)
//  clr             : when enabled, load a bubble instead of the fetched word
//  instr_in, pc_plus4_in : fetched word and its PC+4
//  instr_d, pc_plus4_d, valid_d : registered outputs to decode
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_d    <= NOP_INSTR;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (en) begin
      if (clr) begin
        instr_d    <= NOP_INSTR;
        pc_plus4_d <= '0;
        valid_d    <= 1'b0;
      end else begin
        instr_d    <= instr_in;
        pc_plus4_d <= pc_plus4_in;
        valid_d    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline plus the IF/ID register.
//  Hazard inputs : stall_f (hold PC), stall_d (hold IF/ID)
//  Redirects     : pc_src_d/branch_target_d, sig_jump_d (J / JR), jr_target_d
//  halt_d        : exit syscall, freezes fetch until reset
//  imem_*        : req/ready instruction port; req and addr stay stable until ready
//  pc_f, instr_d, pc_plus4_d, valid_d : fetch PC and IF/ID contents
//  fetch_busy    : request outstanding with no word this cycle
//  halted        : fetch frozen
// No delay slot: every redirect or halt bubbles IF/ID. A redirect that lands
// while a fetch is still outstanding parks the target in pending_pc and the
// FSM waits in DISCARD for the stale word before switching PC.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        pc_src_d,
  input  logic [31:0] branch_target_d,
  input  logic [1:0]  sig_jump_d,
  input  logic [31:0] jr_target_d,
  input  logic        halt_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        fetch_busy,
  output logic        halted
);

  fetch_state_e state, state_n;
  logic [31:0]  pending_pc, pending_pc_n, pc_n, target, pc_inc;
  logic         halt_pend, halt_pend_n;
  logic         redirect, halt_now, ifid_clr;

  // Request drops combinationally under reset so an in-flight fetch is abandoned.
  assign imem_req   = !reset && (state != ST_HALT);
  assign imem_addr  = pc_f;
  assign fetch_busy = imem_req && !imem_ready;
  assign halted     = (state == ST_HALT);
  assign pc_inc     = pc_f + 32'd4;

  // Decode-side requests only count when decode is actually advancing.
  assign halt_now = halt_d && !stall_d;
  assign redirect = !stall_d && (pc_src_d || sig_jump_d == JUMP_J || sig_jump_d == JUMP_JR);

  always_comb begin
    if (pc_src_d)                  target = branch_target_d;
    else if (sig_jump_d == JUMP_JR) target = jr_target_d;
    else                           target = j_target(pc_plus4_d, instr_d);
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc_f;
    pending_pc_n = pending_pc;
    halt_pend_n  = halt_pend;
    ifid_clr     = 1'b1;
    case (state)
      ST_RUN: begin
        if (halt_now) begin
          if (imem_ready) state_n = ST_HALT;
          else begin
            halt_pend_n = 1'b1;
            state_n     = ST_DISCARD;
          end
        end else if (redirect) begin
          if (imem_ready) pc_n = target;
          else begin
            pending_pc_n = target;
            state_n      = ST_DISCARD;
          end
        end else if (imem_ready && !stall_f) begin
          pc_n     = pc_inc;
          ifid_clr = 1'b0;
        end
      end
      ST_DISCARD: begin
        if (halt_now)      halt_pend_n  = 1'b1;
        else if (redirect) pending_pc_n = target;  // last redirect wins
        if (imem_ready) begin
          pc_n    = (redirect && !halt_now) ? target : pending_pc;
          state_n = (halt_pend || halt_now) ? ST_HALT : ST_RUN;
        end
      end
      ST_HALT: ;
      default: state_n = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      pc_f       <= RESET_PC;
      pending_pc <= '0;
      halt_pend  <= 1'b0;
    end else begin
      state      <= state_n;
      pc_f       <= pc_n;
      pending_pc <= pending_pc_n;
      halt_pend  <= halt_pend_n;
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .en         (!stall_d),
    .clr        (ifid_clr),
    .instr_in   (imem_rdata),
    .pc_plus4_in(pc_inc),
    .instr_d    (instr_d),
    .pc_plus4_d (pc_plus4_d),
    .valid_d    (valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: each directed step drives inputs on the
// falling edge and queues the outputs expected after the next rising edge; a
// monitor pops and compares one entry per rising edge. Memory returns its address.
module tb_fetch_stage;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        req;
    logic        busy;
    logic        halt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_f = 1'b0, stall_d = 1'b0, pc_src_d = 1'b0, halt_d = 1'b0;
  logic [31:0] branch_target_d = '0, jr_target_d = '0;
  logic [1:0]  sig_jump_d = 2'b00;
  logic        imem_req, imem_ready = 1'b1;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc_f, instr_d, pc_plus4_d;
  logic        valid_d, fetch_busy, halted;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  assign imem_rdata = imem_addr;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d),
    .pc_src_d(pc_src_d), .branch_target_d(branch_target_d), .sig_jump_d(sig_jump_d),
    .jr_target_d(jr_target_d), .halt_d(halt_d), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .pc_f(pc_f), .instr_d(instr_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
    .fetch_busy(fetch_busy), .halted(halted)
  );

  task automatic compare(input exp_t e);
    n_checks++;
    if (pc_f === e.pc && imem_addr === e.pc && instr_d === e.instr &&
        pc_plus4_d === e.pc4 && valid_d === e.valid && imem_req === e.req &&
        fetch_busy === e.busy && halted === e.halt)
      n_pass++;
    else
      $display("FAIL %s: got pc=%h addr=%h instr=%h pc4=%h v=%b req=%b busy=%b halt=%b, expected pc=%h instr=%h pc4=%h v=%b req=%b busy=%b halt=%b",
               e.name, pc_f, imem_addr, instr_d, pc_plus4_d, valid_d, imem_req, fetch_busy, halted,
               e.pc, e.instr, e.pc4, e.valid, e.req, e.busy, e.halt);
  endtask

  task automatic step(input string nm, input logic rst, rdy, sf, sd, psrc,
                      input logic [31:0] bt, input logic [1:0] jmp, input logic [31:0] jr,
                      input logic hlt, input logic [31:0] epc, ei, ep4,
                      input logic ev, ereq, ebusy, ehalt);
    exp_t e;
    @(negedge clk);
    reset = rst; imem_ready = rdy; stall_f = sf; stall_d = sd; pc_src_d = psrc;
    branch_target_d = bt; sig_jump_d = jmp; jr_target_d = jr; halt_d = hlt;
    e.name = nm; e.pc = epc; e.instr = ei; e.pc4 = ep4;
    e.valid = ev; e.req = ereq; e.busy = ebusy; e.halt = ehalt;
    q.push_back(e);
  endtask

  // Monitor: one expected entry per rising edge, sampled 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        compare(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d entries pending", q.size());
    $fatal(1);
  end

  initial begin
    exp_t e;
    repeat (2) @(posedge clk);
    //    name           rst rdy sf sd ps  bt            jmp    jr            h   pc            instr         pc4           v  req bsy hlt
    step("reset",        1, 1, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h00400000, 32'h0,        32'h0,        0, 0, 0, 0);
    // sequential fetch, zero-wait memory
    step("seq0",         0, 1, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h00400004, 32'h00400000, 32'h00400004, 1, 1, 0, 0);
    step("seq1",         0, 1, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h00400008, 32'h00400004, 32'h00400008, 1, 1, 0, 0);
    // slow memory: three wait cycles
    for (int i = 0; i < 3; i++)
      step("wait",       0, 0, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h00400008, 32'h0,        32'h0,        0, 1, 1, 0);
    step("wait_done",    0, 1, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h0040000C, 32'h00400008, 32'h0040000C, 1, 1, 0, 0);
    // taken branch with ready
    step("branch",       0, 1, 0, 0, 1, 32'h00400100, 2'b00, 32'h0,        0, 32'h00400100, 32'h0,        32'h0,        0, 1, 0, 0);
    step("branch_fetch", 0, 1, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h00400104, 32'h00400100, 32'h00400104, 1, 1, 0, 0);
    // JR while memory is slow: stale word dropped
    step("jr_discard",   0, 0, 0, 0, 0, 32'h0,        2'b10, 32'h00400200, 0, 32'h00400104, 32'h0,        32'h0,        0, 1, 1, 0);
    step("jr_wait",      0, 0, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h00400104, 32'h0,        32'h0,        0, 1, 1, 0);
    step("jr_drop",      0, 1, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h00400200, 32'h0,        32'h0,        0, 1, 0, 0);
    step("jr_fetch",     0, 1, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h00400204, 32'h00400200, 32'h00400204, 1, 1, 0, 0);
    // full stall holds everything
    for (int i = 0; i < 2; i++)
      step("stall",      0, 1, 1, 1, 0, 32'h0,        2'b00, 32'h0,        0, 32'h00400204, 32'h00400200, 32'h00400204, 1, 1, 0, 0);
    step("stall_rel",    0, 1, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h00400208, 32'h00400204, 32'h00400208, 1, 1, 0, 0);
    // redirect under stall_d is ignored
    step("stall_br",     0, 1, 1, 1, 1, 32'h00400300, 2'b00, 32'h0,        0, 32'h00400208, 32'h00400204, 32'h00400208, 1, 1, 0, 0);
    step("stall_br_rel", 0, 1, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h0040020C, 32'h00400208, 32'h0040020C, 1, 1, 0, 0);
    // J: {0, 26'h0400208, 00} = 0x01000820
    step("j",            0, 1, 0, 0, 0, 32'h0,        2'b01, 32'h0,        0, 32'h01000820, 32'h0,        32'h0,        0, 1, 0, 0);
    step("j_fetch",      0, 1, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h01000824, 32'h01000820, 32'h01000824, 1, 1, 0, 0);
    // PC wraps at the top of the address space
    step("jr_top",       0, 1, 0, 0, 0, 32'h0,        2'b10, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 32'h0,        32'h0,        0, 1, 0, 0);
    step("wrap",         0, 1, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h00000000, 32'hFFFFFFFC, 32'h00000000, 1, 1, 0, 0);
    // two redirects while discarding: the later target wins
    step("disc_jr",      0, 0, 0, 0, 0, 32'h0,        2'b10, 32'h00400040, 0, 32'h00000000, 32'h0,        32'h0,        0, 1, 1, 0);
    step("disc_br",      0, 0, 0, 0, 1, 32'h00400080, 2'b00, 32'h0,        0, 32'h00000000, 32'h0,        32'h0,        0, 1, 1, 0);
    step("disc_done",    0, 1, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h00400080, 32'h0,        32'h0,        0, 1, 0, 0);
    step("disc_fetch",   0, 1, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h00400084, 32'h00400080, 32'h00400084, 1, 1, 0, 0);
    // branch beats JR
    step("prio",         0, 1, 0, 0, 1, 32'h00400010, 2'b10, 32'h00500000, 0, 32'h00400010, 32'h0,        32'h0,        0, 1, 0, 0);
    // halt freezes fetch
    step("halt",         0, 1, 0, 0, 0, 32'h0,        2'b00, 32'h0,        1, 32'h00400010, 32'h0,        32'h0,        0, 0, 0, 1);
    for (int i = 0; i < 10; i++)
      step("halted",     0, 1, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h00400010, 32'h0,        32'h0,        0, 0, 0, 1);
    // asynchronous reset mid-cycle takes effect without a clock edge
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    e.name = "async_rst"; e.pc = 32'h00400000; e.instr = 32'h0; e.pc4 = 32'h0;
    e.valid = 1'b0; e.req = 1'b0; e.busy = 1'b0; e.halt = 1'b0;
    compare(e);
    step("rst_hold",     1, 1, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h00400000, 32'h0,        32'h0,        0, 0, 0, 0);
    step("rst_resume",   0, 1, 0, 0, 0, 32'h0,        2'b00, 32'h0,        0, 32'h00400004, 32'h00400000, 32'h00400004, 1, 1, 0, 0);

    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending entries, expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
